// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Word-addressed data memory with a fixed, parameterised response latency.
// A load or store is accepted in IDLE, its address, data and operation are
// latched, and the operation commits LATENCY edges later. Ready then pulses
// for one cycle and the responder returns to IDLE. Requests presented while
// Busy is high are dropped, not queued.
//
// Parameters
//   NBITS   : data width and byte-address width
//   NWORDS  : number of memory words (at most 2^(NBITS-2))
//   LATENCY : edges from acceptance to commit (at least 1)
//
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   Address   : word index, i.e. byte address bits [NBITS-1:2]
//   WriteData : store data
//   MemWrite  : store request (wins when MemRead is also set)
//   MemRead   : load request
//   ReadData  : registered load result, updated only on a read commit
//   Ready     : one-cycle completion pulse
//   Busy      : operation in progress; new requests are ignored
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned NWORDS  = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [NBITS-1:0] ReadData,
  output logic             Ready,
  output logic             Busy
);

  localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned   IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [NBITS-3:0] lat_addr;
  logic [NBITS-1:0] lat_data;
  logic             lat_wr;

  logic [NBITS-1:0] mem [NWORDS];

  logic             accept;
  logic             commit;
  logic             in_range;
  logic [IW-1:0]    idx;

  // Range check uses the full latched index so that out-of-range addresses
  // never alias onto a real word through the truncated array index.
  assign in_range = (32'(lat_addr) < NWORDS);
  assign idx      = lat_addr[IW-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite || MemRead) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    Ready = (state == DONE);
    Busy  = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Request latch and latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else if (accept) begin
      cnt      <= CNT_LOAD;
      lat_addr <= Address;
      lat_data <= WriteData;
      lat_wr   <= MemWrite;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array; out-of-range writes are discarded
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && lat_wr && in_range) begin
      mem[idx] <= lat_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result; out-of-range reads return zero
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ReadData <= '0;
    end else if (commit && !lat_wr) begin
      ReadData <= in_range ? mem[idx] : '0;
    end
  end

endmodule
